// File: rtl/wb_master_arbiter.sv
// wb_master_arbiter: N-master to 1-slave Wishbone B3 arbiter with fixed/round-robin
// arbitration, whole-cycle grant locking and an unanswered-strobe watchdog.
`default_nettype none

module wb_master_arbiter #(
   parameter int NUM_MASTERS    = 2,
   parameter int ADDRESS_WIDTH  = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int ARB_MODE       = 0,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                                clk_i,
   input  logic                                rst_i,
   input  logic [NUM_MASTERS*ADDRESS_WIDTH-1:0] m_adr_i,
   input  logic [NUM_MASTERS*DATA_WIDTH-1:0]    m_dat_i,
   input  logic [NUM_MASTERS*4-1:0]             m_sel_i,
   input  logic [NUM_MASTERS-1:0]               m_we_i,
   input  logic [NUM_MASTERS-1:0]               m_cyc_i,
   input  logic [NUM_MASTERS-1:0]               m_stb_i,
   input  logic [NUM_MASTERS*3-1:0]             m_cti_i,
   input  logic [NUM_MASTERS*2-1:0]             m_bte_i,
   output logic [DATA_WIDTH-1:0]                m_dat_o,
   output logic [NUM_MASTERS-1:0]               m_ack_o,
   output logic [NUM_MASTERS-1:0]               m_err_o,
   output logic [NUM_MASTERS-1:0]               m_rty_o,
   output logic [ADDRESS_WIDTH-1:0]             s_adr_o,
   output logic [DATA_WIDTH-1:0]                s_dat_o,
   output logic [3:0]                           s_sel_o,
   output logic                                 s_we_o,
   output logic [2:0]                           s_cti_o,
   output logic [1:0]                           s_bte_o,
   output logic                                 s_cyc_o,
   output logic                                 s_stb_o,
   input  logic [DATA_WIDTH-1:0]                s_dat_i,
   input  logic                                 s_ack_i,
   input  logic                                 s_err_i,
   input  logic                                 s_rty_i,
   output logic [NUM_MASTERS-1:0]               grant_o,
   output logic                                 timeout_o
);

   localparam int PW = $clog2(NUM_MASTERS);

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_GRANT = 1'b1;

   logic [0:0]             state_q, state_d;
   logic [NUM_MASTERS-1:0] grant_q, grant_d;
   logic [PW-1:0]          gidx_q, gidx_d;
   logic [PW-1:0]          rr_ptr_q, rr_ptr_d;

   logic                   win_vld;
   logic [PW-1:0]          win_idx;
   logic [PW-1:0]          cand;
   logic                   g_cyc;
   logic                   g_stb;
   logic                   in_grant;
   logic                   slv_term;
   logic                   wd_fire;

   assign in_grant = (state_q == ST_GRANT);
   assign g_cyc    = m_cyc_i[gidx_q];
   assign g_stb    = m_stb_i[gidx_q];
   assign slv_term = in_grant && (s_ack_i || s_err_i || s_rty_i);

   // Fixed mode scans from index 0; round-robin scans from the slot after the last winner.
   always_comb begin
      win_vld = 1'b0;
      win_idx = '0;
      cand    = '0;
      for (int k = 0; k < NUM_MASTERS; k++) begin
         if (ARB_MODE == 0) begin
            cand = PW'(k);
         end else begin
            cand = PW'((int'(rr_ptr_q) + 1 + k) % NUM_MASTERS);
         end
         if (!win_vld && m_cyc_i[cand]) begin
            win_vld = 1'b1;
            win_idx = cand;
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      grant_d  = grant_q;
      gidx_d   = gidx_q;
      rr_ptr_d = rr_ptr_q;
      case (state_q)
         ST_IDLE: begin
            if (win_vld) begin
               state_d          = ST_GRANT;
               grant_d          = '0;
               grant_d[win_idx] = 1'b1;
               gidx_d           = win_idx;
               rr_ptr_d         = win_idx;
            end
         end
         default: begin
            if (!g_cyc) begin
               state_d = ST_IDLE;
               grant_d = '0;
            end
         end
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q  <= ST_IDLE;
         grant_q  <= '0;
         gidx_q   <= '0;
         rr_ptr_q <= PW'(NUM_MASTERS - 1);
      end else begin
         state_q  <= state_d;
         grant_q  <= grant_d;
         gidx_q   <= gidx_d;
         rr_ptr_q <= rr_ptr_d;
      end
   end

   generate
      if (TIMEOUT_CYCLES > 0) begin : g_wdog
         localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
         localparam logic [CW-1:0] C_LIMIT = CW'(TIMEOUT_CYCLES);

         logic [CW-1:0] wd_cnt_q, wd_cnt_d;

         // A real slave termination in the firing cycle takes precedence over the forced error.
         assign wd_fire = in_grant && g_stb && !slv_term && (wd_cnt_q == C_LIMIT);

         always_comb begin
            wd_cnt_d = wd_cnt_q;
            if (!in_grant || slv_term || wd_fire) begin
               wd_cnt_d = '0;
            end else if (g_stb && (wd_cnt_q != C_LIMIT)) begin
               wd_cnt_d = wd_cnt_q + 1'b1;
            end
         end

         always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
               wd_cnt_q <= '0;
            end else begin
               wd_cnt_q <= wd_cnt_d;
            end
         end
      end else begin : g_no_wdog
         assign wd_fire = 1'b0;
      end
   endgenerate

   always_comb begin
      s_adr_o = m_adr_i[ADDRESS_WIDTH-1:0];
      s_dat_o = m_dat_i[DATA_WIDTH-1:0];
      s_sel_o = m_sel_i[3:0];
      s_we_o  = m_we_i[0];
      s_cti_o = m_cti_i[2:0];
      s_bte_o = m_bte_i[1:0];
      for (int k = 1; k < NUM_MASTERS; k++) begin
         if (gidx_q == PW'(k)) begin
            s_adr_o = m_adr_i[k*ADDRESS_WIDTH +: ADDRESS_WIDTH];
            s_dat_o = m_dat_i[k*DATA_WIDTH +: DATA_WIDTH];
            s_sel_o = m_sel_i[k*4 +: 4];
            s_we_o  = m_we_i[k];
            s_cti_o = m_cti_i[k*3 +: 3];
            s_bte_o = m_bte_i[k*2 +: 2];
         end
      end
   end

   // grant_q is all-zero outside GRANT, so it doubles as the termination routing mask.
   assign s_cyc_o   = in_grant && g_cyc;
   assign s_stb_o   = in_grant && g_stb && !wd_fire;
   assign m_dat_o   = s_dat_i;
   assign m_ack_o   = s_ack_i ? grant_q : '0;
   assign m_err_o   = (s_err_i || wd_fire) ? grant_q : '0;
   assign m_rty_o   = s_rty_i ? grant_q : '0;
   assign grant_o   = grant_q;
   assign timeout_o = wd_fire;

endmodule

`default_nettype wire

// File: tb/tb_wb_master_arbiter.sv
// tb_wb_master_arbiter: fixed-priority and round-robin arbiters on shared stimulus,
// directed vector table, reset sequence and randomized traffic against a reference model.
`default_nettype none

module tb_wb_master_arbiter;

   localparam int N   = 3;
   localparam int TMO = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [N*32-1:0] m_adr;
   logic [N*32-1:0] m_dat;
   logic [N*4-1:0]  m_sel;
   logic [N-1:0]    m_we, m_cyc, m_stb;
   logic [N*3-1:0]  m_cti;
   logic [N*2-1:0]  m_bte;
   logic [31:0]     s_dat;
   logic            s_ack, s_err, s_rty;

   logic [31:0]  o_mdat [2];
   logic [N-1:0] o_ack  [2];
   logic [N-1:0] o_err  [2];
   logic [N-1:0] o_rty  [2];
   logic [31:0]  o_adr  [2];
   logic [31:0]  o_sdat [2];
   logic [3:0]   o_sel  [2];
   logic         o_we   [2];
   logic [2:0]   o_cti  [2];
   logic [1:0]   o_bte  [2];
   logic         o_scyc [2];
   logic         o_sstb [2];
   logic [N-1:0] o_grant[2];
   logic         o_to   [2];

   int checks = 0;
   int errors = 0;

   // reference model state: owner (-1 = bus idle), last winner, unanswered strobes
   int own  [2];
   int last [2];
   int cnt  [2];

   always #5 clk = ~clk;

   wb_master_arbiter #(.NUM_MASTERS(N), .ADDRESS_WIDTH(32), .DATA_WIDTH(32),
                       .ARB_MODE(0), .TIMEOUT_CYCLES(TMO)) dut_fx (
      .clk_i(clk), .rst_i(rst),
      .m_adr_i(m_adr), .m_dat_i(m_dat), .m_sel_i(m_sel), .m_we_i(m_we),
      .m_cyc_i(m_cyc), .m_stb_i(m_stb), .m_cti_i(m_cti), .m_bte_i(m_bte),
      .m_dat_o(o_mdat[0]), .m_ack_o(o_ack[0]), .m_err_o(o_err[0]), .m_rty_o(o_rty[0]),
      .s_adr_o(o_adr[0]), .s_dat_o(o_sdat[0]), .s_sel_o(o_sel[0]), .s_we_o(o_we[0]),
      .s_cti_o(o_cti[0]), .s_bte_o(o_bte[0]), .s_cyc_o(o_scyc[0]), .s_stb_o(o_sstb[0]),
      .s_dat_i(s_dat), .s_ack_i(s_ack), .s_err_i(s_err), .s_rty_i(s_rty),
      .grant_o(o_grant[0]), .timeout_o(o_to[0])
   );

   wb_master_arbiter #(.NUM_MASTERS(N), .ADDRESS_WIDTH(32), .DATA_WIDTH(32),
                       .ARB_MODE(1), .TIMEOUT_CYCLES(TMO)) dut_rr (
      .clk_i(clk), .rst_i(rst),
      .m_adr_i(m_adr), .m_dat_i(m_dat), .m_sel_i(m_sel), .m_we_i(m_we),
      .m_cyc_i(m_cyc), .m_stb_i(m_stb), .m_cti_i(m_cti), .m_bte_i(m_bte),
      .m_dat_o(o_mdat[1]), .m_ack_o(o_ack[1]), .m_err_o(o_err[1]), .m_rty_o(o_rty[1]),
      .s_adr_o(o_adr[1]), .s_dat_o(o_sdat[1]), .s_sel_o(o_sel[1]), .s_we_o(o_we[1]),
      .s_cti_o(o_cti[1]), .s_bte_o(o_bte[1]), .s_cyc_o(o_scyc[1]), .s_stb_o(o_sstb[1]),
      .s_dat_i(s_dat), .s_ack_i(s_ack), .s_err_i(s_err), .s_rty_i(s_rty),
      .grant_o(o_grant[1]), .timeout_o(o_to[1])
   );

   typedef struct {
      logic [2:0] cyc;
      logic [2:0] stb;
      logic [2:0] cti0;
      logic       ack;
      logic [2:0] eg_fx;
      logic [2:0] eg_rr;
      logic       eto;
   } row_t;

   row_t tbl[$];

   task automatic add(input logic [2:0] c, input logic [2:0] s, input logic [2:0] t,
                      input logic a, input logic [2:0] gf, input logic [2:0] gr,
                      input logic e);
      row_t r;
      r.cyc = c; r.stb = s; r.cti0 = t; r.ack = a; r.eg_fx = gf; r.eg_rr = gr; r.eto = e;
      tbl.push_back(r);
   endtask

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         own[d]  = -1;
         last[d] = N - 1;
         cnt[d]  = 0;
      end
   endtask

   // Compare both DUTs against the model for the current cycle, then advance the model.
   task automatic model_check();
      int         o, c;
      logic [2:0] eg;
      logic       cg, sg, term, fire;
      string      p;
      for (int d = 0; d < 2; d++) begin
         p    = (d == 0) ? "fx" : "rr";
         o    = own[d];
         eg   = (o < 0) ? 3'b000 : 3'(1 << o);
         cg   = (o < 0) ? 1'b0 : m_cyc[o];
         sg   = (o < 0) ? 1'b0 : m_stb[o];
         term = (o >= 0) && (s_ack || s_err || s_rty);
         fire = (o >= 0) && sg && !term && (cnt[d] == TMO);
         chk({p, "_mdl_grant"}, 64'(o_grant[d]), 64'(eg));
         chk({p, "_mdl_scyc"},  64'(o_scyc[d]),  64'(cg));
         chk({p, "_mdl_sstb"},  64'(o_sstb[d]),  64'(sg && !fire));
         chk({p, "_mdl_ack"},   64'(o_ack[d]),   64'(s_ack ? eg : 3'b000));
         chk({p, "_mdl_err"},   64'(o_err[d]),   64'((s_err || fire) ? eg : 3'b000));
         chk({p, "_mdl_rty"},   64'(o_rty[d]),   64'(s_rty ? eg : 3'b000));
         chk({p, "_mdl_to"},    64'(o_to[d]),    64'(fire));
         chk({p, "_mdl_mdat"},  64'(o_mdat[d]),  64'(s_dat));
         if (o >= 0) begin
            chk({p, "_mdl_adr"}, 64'(o_adr[d]),  64'(m_adr[o*32 +: 32]));
            chk({p, "_mdl_dat"}, 64'(o_sdat[d]), 64'(m_dat[o*32 +: 32]));
            chk({p, "_mdl_sel"}, 64'(o_sel[d]),  64'(m_sel[o*4 +: 4]));
            chk({p, "_mdl_we"},  64'(o_we[d]),   64'(m_we[o]));
            chk({p, "_mdl_cti"}, 64'(o_cti[d]),  64'(m_cti[o*3 +: 3]));
            chk({p, "_mdl_bte"}, 64'(o_bte[d]),  64'(m_bte[o*2 +: 2]));
         end
         if (o < 0 || term || fire) cnt[d] = 0;
         else if (sg && cnt[d] < TMO) cnt[d] = cnt[d] + 1;
         if (o < 0) begin
            for (int k = 0; k < N; k++) begin
               c = (d == 0) ? k : (last[d] + 1 + k) % N;
               if (m_cyc[c]) begin
                  own[d]  = c;
                  last[d] = c;
                  break;
               end
            end
         end else if (!cg) begin
            own[d] = -1;
         end
      end
   endtask

   initial begin
      m_adr = {32'h0000_3000, 32'h0000_2000, 32'h0000_1000};
      m_dat = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
      m_sel = '1; m_we = '0; m_cyc = '0; m_stb = '0; m_cti = '0; m_bte = '0;
      s_dat = '0; s_ack = 1'b0; s_err = 1'b0; s_rty = 1'b0;
      model_reset();

      repeat (2) @(negedge clk);
      #2;
      for (int d = 0; d < 2; d++) begin
         chk("rst_grant", 64'(o_grant[d]), 64'd0);
         chk("rst_scyc",  64'(o_scyc[d]),  64'd0);
         chk("rst_sstb",  64'(o_sstb[d]),  64'd0);
         chk("rst_term",  64'({o_ack[d], o_err[d], o_rty[d]}), 64'd0);
         chk("rst_to",    64'(o_to[d]),    64'd0);
      end
      @(negedge clk);
      rst = 1'b0;

      // single read, fixed priority, idle gap between owners
      add(3'b001, 3'b001, 3'b000, 0, 3'b000, 3'b000, 0);
      add(3'b001, 3'b001, 3'b000, 1, 3'b001, 3'b001, 0);
      add(3'b011, 3'b011, 3'b000, 0, 3'b001, 3'b001, 0);
      add(3'b011, 3'b011, 3'b000, 1, 3'b001, 3'b001, 0);
      add(3'b010, 3'b010, 3'b000, 0, 3'b001, 3'b001, 0);
      add(3'b010, 3'b010, 3'b000, 0, 3'b000, 3'b000, 0);
      add(3'b010, 3'b010, 3'b000, 1, 3'b010, 3'b010, 0);
      add(3'b000, 3'b000, 3'b000, 0, 3'b010, 3'b010, 0);
      add(3'b000, 3'b000, 3'b000, 0, 3'b000, 3'b000, 0);
      // 4-beat incrementing burst, m1 requests at beat 2
      add(3'b001, 3'b001, 3'b010, 0, 3'b000, 3'b000, 0);
      add(3'b001, 3'b001, 3'b010, 1, 3'b001, 3'b001, 0);
      add(3'b011, 3'b011, 3'b010, 1, 3'b001, 3'b001, 0);
      add(3'b011, 3'b011, 3'b010, 1, 3'b001, 3'b001, 0);
      add(3'b011, 3'b011, 3'b111, 1, 3'b001, 3'b001, 0);
      add(3'b010, 3'b010, 3'b000, 0, 3'b001, 3'b001, 0);
      add(3'b010, 3'b010, 3'b000, 0, 3'b000, 3'b000, 0);
      add(3'b010, 3'b010, 3'b000, 1, 3'b010, 3'b010, 0);
      add(3'b000, 3'b000, 3'b000, 0, 3'b010, 3'b010, 0);
      add(3'b000, 3'b000, 3'b000, 0, 3'b000, 3'b000, 0);
      // m0 and m1 both requesting: fixed keeps m0, round-robin alternates
      add(3'b011, 3'b011, 3'b000, 0, 3'b000, 3'b000, 0);
      add(3'b011, 3'b011, 3'b000, 1, 3'b001, 3'b001, 0);
      add(3'b010, 3'b010, 3'b000, 0, 3'b001, 3'b001, 0);
      add(3'b011, 3'b011, 3'b000, 0, 3'b000, 3'b000, 0);
      add(3'b011, 3'b011, 3'b000, 1, 3'b001, 3'b010, 0);
      add(3'b000, 3'b000, 3'b000, 0, 3'b001, 3'b010, 0);
      add(3'b011, 3'b011, 3'b000, 0, 3'b000, 3'b000, 0);
      add(3'b011, 3'b011, 3'b000, 1, 3'b001, 3'b001, 0);
      add(3'b000, 3'b000, 3'b000, 0, 3'b001, 3'b001, 0);
      add(3'b011, 3'b011, 3'b000, 0, 3'b000, 3'b000, 0);
      add(3'b011, 3'b011, 3'b000, 1, 3'b001, 3'b010, 0);
      add(3'b000, 3'b000, 3'b000, 0, 3'b001, 3'b010, 0);
      add(3'b000, 3'b000, 3'b000, 0, 3'b000, 3'b000, 0);
      // watchdog: 4 unanswered strobes then forced error; later ack in firing cycle wins
      add(3'b001, 3'b001, 3'b000, 0, 3'b000, 3'b000, 0);
      for (int k = 0; k < 4; k++) add(3'b001, 3'b001, 3'b000, 0, 3'b001, 3'b001, 0);
      add(3'b001, 3'b001, 3'b000, 0, 3'b001, 3'b001, 1);
      for (int k = 0; k < 4; k++) add(3'b001, 3'b001, 3'b000, 0, 3'b001, 3'b001, 0);
      add(3'b001, 3'b001, 3'b000, 1, 3'b001, 3'b001, 0);
      add(3'b000, 3'b000, 3'b000, 0, 3'b001, 3'b001, 0);
      add(3'b000, 3'b000, 3'b000, 0, 3'b000, 3'b000, 0);

      foreach (tbl[i]) begin
         @(negedge clk);
         m_cyc = tbl[i].cyc;
         m_stb = tbl[i].stb;
         m_cti = {6'b000000, tbl[i].cti0};
         s_ack = tbl[i].ack;
         s_dat = (i == 1) ? 32'hDEAD_BEEF : $urandom;
         #2;
         chk($sformatf("tbl%0d_grant_fx", i), 64'(o_grant[0]), 64'(tbl[i].eg_fx));
         chk($sformatf("tbl%0d_grant_rr", i), 64'(o_grant[1]), 64'(tbl[i].eg_rr));
         chk($sformatf("tbl%0d_scyc_fx", i), 64'(o_scyc[0]), 64'(|(tbl[i].eg_fx & tbl[i].cyc)));
         chk($sformatf("tbl%0d_sstb_fx", i), 64'(o_sstb[0]),
             64'((|(tbl[i].eg_fx & tbl[i].stb)) && !tbl[i].eto));
         chk($sformatf("tbl%0d_ack_fx", i), 64'(o_ack[0]), 64'(tbl[i].ack ? tbl[i].eg_fx : 3'b000));
         chk($sformatf("tbl%0d_ack_rr", i), 64'(o_ack[1]), 64'(tbl[i].ack ? tbl[i].eg_rr : 3'b000));
         chk($sformatf("tbl%0d_err_fx", i), 64'(o_err[0]), 64'(tbl[i].eto ? tbl[i].eg_fx : 3'b000));
         chk($sformatf("tbl%0d_to_fx", i), 64'(o_to[0]), 64'(tbl[i].eto));
         chk($sformatf("tbl%0d_to_rr", i), 64'(o_to[1]), 64'(tbl[i].eto));
         chk($sformatf("tbl%0d_mdat", i), 64'(o_mdat[0]), 64'(s_dat));
         if (tbl[i].eg_fx == 3'b001) begin
            chk($sformatf("tbl%0d_adr_fx", i), 64'(o_adr[0]), 64'h1000);
            chk($sformatf("tbl%0d_cti_fx", i), 64'(o_cti[0]), 64'(tbl[i].cti0));
         end
         if (tbl[i].eg_rr == 3'b010)
            chk($sformatf("tbl%0d_adr_rr", i), 64'(o_adr[1]), 64'h2000);
         model_check();
      end

      // asynchronous reset in the middle of an m1 cycle
      @(negedge clk);
      s_ack = 1'b0; m_cyc = 3'b010; m_stb = 3'b010;
      #2 model_check();
      @(negedge clk);
      #2 model_check();
      chk("pre_rst_grant_fx", 64'(o_grant[0]), 64'b010);
      #1 rst = 1'b1;
      #1;
      for (int d = 0; d < 2; d++) begin
         chk("async_rst_grant", 64'(o_grant[d]), 64'd0);
         chk("async_rst_scyc",  64'(o_scyc[d]),  64'd0);
         chk("async_rst_term",  64'({o_ack[d], o_err[d], o_rty[d]}), 64'd0);
      end
      model_reset();
      @(negedge clk);
      rst = 1'b0; m_cyc = 3'b001; m_stb = 3'b001;
      #2 model_check();
      @(negedge clk);
      #2;
      chk("post_rst_grant_fx", 64'(o_grant[0]), 64'b001);
      chk("post_rst_grant_rr", 64'(o_grant[1]), 64'b001);
      model_check();

      // randomized traffic against the reference model
      for (int t = 0; t < 3000; t++) begin
         @(negedge clk);
         for (int k = 0; k < N; k++) begin
            if (m_cyc[k]) m_cyc[k] = ($urandom_range(5) != 0);
            else          m_cyc[k] = ($urandom_range(3) == 0);
            m_stb[k] = m_cyc[k] && ($urandom_range(7) != 0);
         end
         m_adr = {$urandom, $urandom, $urandom};
         m_dat = {$urandom, $urandom, $urandom};
         m_sel = N*4'($urandom);
         m_we  = N'($urandom);
         m_cti = N*3'($urandom);
         m_bte = N*2'($urandom);
         s_dat = $urandom;
         case ($urandom_range(11))
            0, 1:    begin s_ack = 1'b1; s_err = 1'b0; s_rty = 1'b0; end
            2:       begin s_ack = 1'b0; s_err = 1'b1; s_rty = 1'b0; end
            3:       begin s_ack = 1'b0; s_err = 1'b0; s_rty = 1'b1; end
            default: begin s_ack = 1'b0; s_err = 1'b0; s_rty = 1'b0; end
         endcase
         #2 model_check();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
